// File: rtl/apb_ucpd_tx_arb_if.sv
// Request/completion/status bundle between the UCPD transmit arbiter and its
// neighbours (register block, PHY core). Clock and reset stay outside.
interface apb_ucpd_tx_arb_if;
  logic       ucpden;
  logic       hrst_req;
  logic       crst_req;
  logic       msg_req;
  logic       bist_req;
  logic [4:0] ifrgap;
  logic       bit_clk_red;
  logic       receive_en;
  logic       txsend_clr;
  logic       txhrst_clr;
  logic       transmit_en;
  logic       tx_hrst;
  logic [1:0] tx_mode;
  logic [3:0] pending;
  logic       busy;
  logic       txmsgsent;
  logic       hrstsent;
  logic       msg_disc;
  logic       tx_timeout;

  modport master (
    output ucpden, hrst_req, crst_req, msg_req, bist_req, ifrgap,
           bit_clk_red, receive_en, txsend_clr, txhrst_clr,
    input  transmit_en, tx_hrst, tx_mode, pending, busy,
           txmsgsent, hrstsent, msg_disc, tx_timeout
  );

  modport slave (
    input  ucpden, hrst_req, crst_req, msg_req, bist_req, ifrgap,
           bit_clk_red, receive_en, txsend_clr, txhrst_clr,
    output transmit_en, tx_hrst, tx_mode, pending, busy,
           txmsgsent, hrstsent, msg_disc, tx_timeout
  );
endinterface

// File: rtl/apb_ucpd_tx_arb.sv
// UCPD transmit arbiter: latches hard-reset/cable-reset/message/BIST requests,
// grants them by priority, enforces the interframe gap and a completion watchdog.
module apb_ucpd_tx_arb #(
  parameter int TO_W   = 10,
  parameter int TO_MAX = 1000
) (
  input logic              ic_clk,
  input logic              ic_rst,
  apb_ucpd_tx_arb_if.slave bus
);

  typedef enum logic [1:0] {IDLE, BUSY_TX, BUSY_HRST, GAP} state_e;

  localparam logic [TO_W-1:0] WD_LIM = TO_W'(TO_MAX);
  localparam logic [TO_W-1:0] WD_ONE = TO_W'(1);

  // Pending bit positions, matching the {bist, msg, crst, hrst} output order.
  localparam int P_HRST = 0;
  localparam int P_CRST = 1;
  localparam int P_MSG  = 2;
  localparam int P_BIST = 3;

  state_e          state_q, state_d;
  logic [3:0]      pending_q, pending_d;
  logic [1:0]      tx_mode_q, tx_mode_d;
  logic [4:0]      gap_q, gap_d;
  logic [TO_W-1:0] wd_q, wd_d;
  logic            txmsgsent_q, txmsgsent_d;
  logic            hrstsent_q, hrstsent_d;
  logic            msg_disc_q, msg_disc_d;
  logic            tx_timeout_q, tx_timeout_d;

  logic [3:0]      req;
  assign req = {bus.bist_req, bus.msg_req, bus.crst_req, bus.hrst_req};

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
    state_d      = state_q;
    pending_d    = pending_q | req;
    tx_mode_d    = tx_mode_q;
    gap_d        = gap_q;
    wd_d         = wd_q;
    txmsgsent_d  = 1'b0;
    hrstsent_d   = 1'b0;
    msg_disc_d   = 1'b0;
    tx_timeout_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (pending_q[P_HRST]) begin
          state_d           = BUSY_HRST;
          pending_d[P_HRST] = req[P_HRST];
          wd_d              = '0;
        end else if (!bus.receive_en) begin
          if (pending_q[P_CRST]) begin
            state_d           = BUSY_TX;
            pending_d[P_CRST] = req[P_CRST];
            tx_mode_d         = 2'b01;
            wd_d              = '0;
          end else if (pending_q[P_MSG]) begin
            state_d          = BUSY_TX;
            pending_d[P_MSG] = req[P_MSG];
            tx_mode_d        = 2'b00;
            wd_d             = '0;
          end else if (pending_q[P_BIST]) begin
            state_d           = BUSY_TX;
            pending_d[P_BIST] = req[P_BIST];
            tx_mode_d         = 2'b10;
            wd_d              = '0;
          end
        end
      end

      BUSY_TX: begin
        // A hard reset aborts the running frame outright; the frame is not re-queued.
        if (pending_q[P_HRST]) begin
          state_d           = BUSY_HRST;
          pending_d[P_HRST] = req[P_HRST];
          msg_disc_d        = 1'b1;
          wd_d              = '0;
        end else if (bus.txsend_clr) begin
          state_d     = GAP;
          gap_d       = bus.ifrgap;
          txmsgsent_d = 1'b1;
        end else if (wd_q == WD_LIM) begin
          state_d      = GAP;
          gap_d        = bus.ifrgap;
          tx_timeout_d = 1'b1;
        end else if (bus.bit_clk_red) begin
          wd_d = wd_q + WD_ONE;
        end
      end

      BUSY_HRST: begin
        if (bus.txhrst_clr) begin
          state_d    = GAP;
          gap_d      = bus.ifrgap;
          hrstsent_d = 1'b1;
        end else if (wd_q == WD_LIM) begin
          state_d      = GAP;
          gap_d        = bus.ifrgap;
          tx_timeout_d = 1'b1;
        end else if (bus.bit_clk_red) begin
          wd_d = wd_q + WD_ONE;
        end
      end

      GAP: begin
        if (pending_q[P_HRST]) begin
          state_d           = BUSY_HRST;
          pending_d[P_HRST] = req[P_HRST];
          wd_d              = '0;
        end else if (gap_q == 5'd0) begin
          state_d = IDLE;
        end else if (bus.bit_clk_red) begin
          gap_d = gap_q - 5'd1;
        end
      end

      default: state_d = IDLE;
    endcase

    // Disabling the block wins over everything computed above.
    if (!bus.ucpden) begin
      state_d      = IDLE;
      pending_d    = '0;
      tx_mode_d    = 2'b00;
      gap_d        = '0;
      wd_d         = '0;
      txmsgsent_d  = 1'b0;
      hrstsent_d   = 1'b0;
      msg_disc_d   = 1'b0;
      tx_timeout_d = 1'b0;
    end
  end

  // NOTE: state flops use non-blocking assignments and an asynchronous reset term in the sensitivity list.
  always_ff @(posedge ic_clk or posedge ic_rst) begin
    if (ic_rst) begin
      state_q      <= IDLE;
      pending_q    <= '0;
      tx_mode_q    <= 2'b00;
      gap_q        <= '0;
      wd_q         <= '0;
      txmsgsent_q  <= 1'b0;
      hrstsent_q   <= 1'b0;
      msg_disc_q   <= 1'b0;
      tx_timeout_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pending_q    <= pending_d;
      tx_mode_q    <= tx_mode_d;
      gap_q        <= gap_d;
      wd_q         <= wd_d;
      txmsgsent_q  <= txmsgsent_d;
      hrstsent_q   <= hrstsent_d;
      msg_disc_q   <= msg_disc_d;
      tx_timeout_q <= tx_timeout_d;
    end
  end

  assign bus.transmit_en = (state_q == BUSY_TX);
  assign bus.tx_hrst     = (state_q == BUSY_HRST);
  assign bus.busy        = (state_q != IDLE);
  assign bus.tx_mode     = tx_mode_q;
  assign bus.pending     = pending_q;
  assign bus.txmsgsent   = txmsgsent_q;
  assign bus.hrstsent    = hrstsent_q;
  assign bus.msg_disc    = msg_disc_q;
  assign bus.tx_timeout  = tx_timeout_q;

endmodule

// File: tb/tb_apb_ucpd_tx_arb.sv
// Directed self-checking bench for apb_ucpd_tx_arb (watchdog shortened to 8 ticks).
module tb_apb_ucpd_tx_arb;

  logic ic_clk = 1'b0;
  logic ic_rst = 1'b1;
  int   n_cmp  = 0;
  int   n_err  = 0;
  int   cycles;

  apb_ucpd_tx_arb_if bus ();

  apb_ucpd_tx_arb #(.TO_W(10), .TO_MAX(8)) dut (
    .ic_clk (ic_clk),
    .ic_rst (ic_rst),
    .bus    (bus)
  );

  always #5 ic_clk = ~ic_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock edge; outputs are sampled 1ns after it, inputs set then take effect next edge.
  task automatic step();
    @(posedge ic_clk);
    #1;
  endtask

  task automatic pulse_req(input logic [3:0] r);
    {bus.bist_req, bus.msg_req, bus.crst_req, bus.hrst_req} = r;
    step();
    {bus.bist_req, bus.msg_req, bus.crst_req, bus.hrst_req} = 4'b0000;
  endtask

  task automatic send_done();
    bus.txsend_clr = 1'b1;
    step();
    bus.txsend_clr = 1'b0;
  endtask

  task automatic hrst_done();
    bus.txhrst_clr = 1'b1;
    step();
    bus.txhrst_clr = 1'b0;
  endtask

  // Count edges until busy drops, bounded so a stuck design still reaches the summary.
  task automatic wait_idle(output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (bus.busy && n < 40);
  endtask

  initial begin
    bus.ucpden      = 1'b1;
    bus.hrst_req    = 1'b0;
    bus.crst_req    = 1'b0;
    bus.msg_req     = 1'b0;
    bus.bist_req    = 1'b0;
    bus.ifrgap      = 5'd0;
    bus.bit_clk_red = 1'b0;
    bus.receive_en  = 1'b0;
    bus.txsend_clr  = 1'b0;
    bus.txhrst_clr  = 1'b0;

    // Reset state, with a request held to show it is ignored during reset.
    bus.msg_req = 1'b1;
    repeat (2) @(posedge ic_clk);
    #1;
    check("rst_pending", 32'(bus.pending), 32'h0);
    check("rst_busy", 32'(bus.busy), 32'h0);
    check("rst_outs", 32'({bus.transmit_en, bus.tx_hrst, bus.tx_mode, bus.txmsgsent,
                           bus.hrstsent, bus.msg_disc, bus.tx_timeout}), 32'h0);
    bus.msg_req = 1'b0;
    ic_rst      = 1'b0;
    step();

    // Single message: latched at edge k, transmitting at k+1, completion, one-cycle gap.
    pulse_req(4'b0100);
    check("msg_pending", 32'(bus.pending), 32'h4);
    check("msg_not_yet", 32'(bus.transmit_en), 32'h0);
    step();
    check("msg_tx_en", 32'(bus.transmit_en), 32'h1);
    check("msg_mode", 32'(bus.tx_mode), 32'h0);
    check("msg_grant_clr", 32'(bus.pending), 32'h0);
    step();
    check("msg_hold", 32'(bus.transmit_en), 32'h1);
    send_done();
    check("msg_sent", 32'(bus.txmsgsent), 32'h1);
    check("msg_gap", 32'({bus.busy, bus.transmit_en}), 32'h2);
    step();
    check("msg_sent_1cyc", 32'(bus.txmsgsent), 32'h0);
    check("msg_idle", 32'(bus.busy), 32'h0);
    send_done();
    check("clr_ignored_idle", 32'({bus.txmsgsent, bus.busy}), 32'h0);

    // Cable reset beats message on the same edge; message follows after the gap.
    pulse_req(4'b0110);
    check("pri_pending", 32'(bus.pending), 32'h6);
    step();
    check("pri_crst_mode", 32'({bus.transmit_en, bus.tx_mode}), 32'h5);
    check("pri_msg_left", 32'(bus.pending), 32'h4);
    send_done();
    step();
    check("pri_gap_done", 32'(bus.busy), 32'h0);
    step();
    check("pri_msg_mode", 32'({bus.transmit_en, bus.tx_mode}), 32'h4);
    check("pri_all_clr", 32'(bus.pending), 32'h0);
    send_done();
    step();

    // Hard reset aborts a running message.
    pulse_req(4'b0100);
    step();
    check("abort_tx", 32'(bus.transmit_en), 32'h1);
    pulse_req(4'b0001);
    check("abort_pend", 32'(bus.pending), 32'h1);
    check("abort_still_tx", 32'(bus.transmit_en), 32'h1);
    step();
    check("abort_disc", 32'(bus.msg_disc), 32'h1);
    check("abort_hrst", 32'({bus.tx_hrst, bus.transmit_en}), 32'h2);
    check("abort_pend_clr", 32'(bus.pending), 32'h0);
    step();
    check("abort_disc_1cyc", 32'(bus.msg_disc), 32'h0);
    hrst_done();
    check("hrst_sent", 32'({bus.hrstsent, bus.tx_hrst}), 32'h2);
    step();
    check("hrst_sent_1cyc", 32'(bus.hrstsent), 32'h0);
    check("hrst_idle", 32'(bus.busy), 32'h0);

    // Abort wins over a same-cycle completion.
    pulse_req(4'b0100);
    step();
    pulse_req(4'b0001);
    bus.txsend_clr = 1'b1;
    step();
    bus.txsend_clr = 1'b0;
    check("abort_vs_done", 32'({bus.msg_disc, bus.txmsgsent, bus.tx_hrst}), 32'h5);
    hrst_done();
    step();

    // Interframe gap of 3 ticks: 3 ticks plus one cycle back to IDLE.
    bus.ifrgap = 5'd3;
    pulse_req(4'b0100);
    step();
    send_done();
    bus.bit_clk_red = 1'b1;
    wait_idle(cycles);
    bus.bit_clk_red = 1'b0;
    check("gap3_cycles", 32'(cycles), 32'd4);
    bus.ifrgap = 5'd0;
    pulse_req(4'b0100);
    step();
    send_done();
    wait_idle(cycles);
    check("gap0_cycles", 32'(cycles), 32'd1);

    // Watchdog expiry after the 8th tick with no completion.
    pulse_req(4'b0100);
    step();
    bus.bit_clk_red = 1'b1;
    repeat (8) step();
    bus.bit_clk_red = 1'b0;
    check("wd_pre", 32'({bus.tx_timeout, bus.transmit_en}), 32'h1);
    step();
    check("wd_fire", 32'({bus.tx_timeout, bus.transmit_en, bus.busy}), 32'h5);
    step();
    check("wd_1cyc", 32'({bus.tx_timeout, bus.busy}), 32'h0);

    // Completion in the expiry cycle wins.
    pulse_req(4'b0100);
    step();
    bus.bit_clk_red = 1'b1;
    repeat (8) step();
    bus.bit_clk_red = 1'b0;
    send_done();
    check("wd_vs_done", 32'({bus.txmsgsent, bus.tx_timeout}), 32'h2);
    step();
    check("wd_vs_done_after", 32'({bus.tx_timeout, bus.busy}), 32'h0);

    // Receive in progress: hard reset goes, message waits for receive_en to drop.
    bus.receive_en = 1'b1;
    pulse_req(4'b0101);
    check("rx_pending", 32'(bus.pending), 32'h5);
    step();
    check("rx_hrst", 32'({bus.tx_hrst, bus.transmit_en}), 32'h2);
    check("rx_msg_held", 32'(bus.pending), 32'h4);
    hrst_done();
    step();
    step();
    check("rx_wait", 32'({bus.busy, bus.pending}), 32'h4);
    bus.receive_en = 1'b0;
    step();
    check("rx_released", 32'({bus.transmit_en, bus.pending}), 32'h10);
    send_done();
    step();

    // BIST mode, then disable mid-transmission.
    pulse_req(4'b1000);
    step();
    check("bist_mode", 32'({bus.transmit_en, bus.tx_mode}), 32'h6);
    pulse_req(4'b0010);
    check("bist_crst_pend", 32'(bus.pending), 32'h2);
    bus.ucpden = 1'b0;
    step();
    check("dis_all", 32'({bus.busy, bus.transmit_en, bus.tx_mode, bus.pending}), 32'h0);
    pulse_req(4'b1111);
    check("dis_ignore", 32'({bus.busy, bus.pending}), 32'h0);
    bus.ucpden = 1'b1;
    step();

    // Asynchronous reset mid-transmission.
    pulse_req(4'b0100);
    step();
    check("art_tx", 32'(bus.transmit_en), 32'h1);
    #2;
    ic_rst = 1'b1;
    #1;
    check("art_drop", 32'({bus.transmit_en, bus.tx_hrst, bus.txmsgsent, bus.busy}), 32'h0);
    step();
    ic_rst = 1'b0;
    step();
    check("art_after", 32'({bus.txmsgsent, bus.busy}), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/apb_ucpd_tx_arb.md
APB_UCPD_TX_ARB -- requirements
Module: apb_ucpd_tx_arb

Interface
REQ-001 SHALL have parameter TO_W, default 10, width of the completion watchdog counter.
REQ-002 SHALL have parameter TO_MAX, default 1000, watchdog limit in bit_clk_red ticks (< 2^TO_W).
REQ-003 SHALL have ports:
- ic_clk  in  1  sole clock.
- ic_rst  in  1  asynchronous, active-high reset.
- ucpden  in  1  block enable.
- hrst_req  in  1  hard-reset request pulse.
- crst_req  in  1  cable-reset request pulse.
- msg_req  in  1  SOP message request pulse.
- bist_req  in  1  BIST carrier request pulse.
- ifrgap  in  5  interframe gap, in bit_clk_red ticks.
- bit_clk_red  in  1  bit-clock tick.
- receive_en  in  1  PHY receiving.
- txsend_clr  in  1  core: message/cable/BIST done.
- txhrst_clr  in  1  core: hard reset done.
- transmit_en  out  1  level, non-hard-reset transmission active.
- tx_hrst  out  1  level, hard reset transmission active.
- tx_mode  out  2  00 SOP, 01 cable reset, 10 BIST.
- pending  out  4  {bist, msg, crst, hrst} latched requests.
- busy  out  1  state not IDLE.
- txmsgsent  out  1  pulse, non-hard-reset completion.
- hrstsent  out  1  pulse, hard reset completion.
- msg_disc  out  1  pulse, active transmission aborted by hard reset.
- tx_timeout  out  1  pulse, watchdog expiry.

Function
REQ-004 SHALL implement states IDLE, BUSY_TX, BUSY_HRST and GAP.
REQ-005 A request pulse sampled at edge k while ucpden=1 SHALL set its pending bit at edge k.
REQ-006 Priority SHALL be hrst > crst > msg > bist.
REQ-007 In IDLE, pending hrst SHALL go to BUSY_HRST at the next edge regardless of receive_en.
REQ-008 In IDLE with receive_en=0, the highest other pending request SHALL go to BUSY_TX at the next edge, with tx_mode loaded per REQ-003.
REQ-009 In IDLE with receive_en=1, crst, msg and bist SHALL wait and stay pending.
REQ-010 On grant, the granted pending bit SHALL clear at the same edge; a re-request during service SHALL set it again.
REQ-011 transmit_en SHALL equal (state==BUSY_TX).
REQ-012 tx_hrst SHALL equal (state==BUSY_HRST).
REQ-013 tx_mode SHALL hold its value until the next grant.
REQ-014 In BUSY_TX, txsend_clr=1 SHALL pulse txmsgsent for one cycle and go to GAP.
REQ-015 In BUSY_HRST, txhrst_clr=1 SHALL pulse hrstsent for one cycle and go to GAP.
REQ-016 txsend_clr or txhrst_clr in any other state SHALL be ignored.
REQ-017 In BUSY_TX with pending hrst, the block SHALL pulse msg_disc and go directly to BUSY_HRST; the aborted request SHALL be discarded, not re-queued.
REQ-018 In BUSY_TX, an hrst abort SHALL take precedence over a same-cycle txsend_clr; txmsgsent SHALL NOT pulse.
REQ-019 On GAP entry, the gap counter SHALL load ifrgap and decrement on each bit_clk_red.
REQ-020 GAP SHALL go to IDLE on the edge after the counter reaches 0; with ifrgap=0, GAP SHALL last exactly one cycle.
REQ-021 Pending hrst in GAP SHALL go directly to BUSY_HRST.
REQ-022 In BUSY states, the watchdog SHALL count bit_clk_red ticks and clear on entry to any BUSY state.
REQ-023 When the watchdog count equals TO_MAX, the block SHALL pulse tx_timeout and go to GAP.
REQ-024 A completion in the same cycle as watchdog expiry SHALL win; tx_timeout SHALL NOT pulse.
REQ-025 With ucpden=0, the next edge SHALL force IDLE, clear pending and all counters, deassert all outputs, and ignore requests.
REQ-026 All pulses SHALL be registered and exactly one cycle wide.

Reset
REQ-027 On ic_rst=1, asynchronously: state=IDLE, pending=0, tx_mode=00, counters=0, all outputs 0.
REQ-028 Reset mid-transmission SHALL drop transmit_en and tx_hrst immediately, with no completion pulse.

Verification
REQ-029 The bench SHALL cover these scenarios:
- msg_req at edge k, receive_en=0 -> transmit_en=1 at k+1, tx_mode=00; txsend_clr -> txmsgsent 1 cycle, GAP.
- crst_req and msg_req same edge -> crst granted first (tx_mode=01); after gap, msg served with tx_mode=00.
- msg in BUSY_TX, hrst_req -> msg_disc pulse, tx_hrst=1 next edge, transmit_en=0, msg bit clear; txhrst_clr -> hrstsent.
- ifrgap=3 after completion -> IDLE re-entered after 3 bit_clk_red ticks plus 1 cycle; ifrgap=0 -> 1 GAP cycle.
- TO_MAX=8, no completion -> tx_timeout after 8th tick; completion on 8th tick -> txmsgsent only.
- receive_en=1 with msg and hrst pending -> hrst granted, msg held until receive_en=0; ucpden=0 -> pending=0000 next edge.
